ula_contention_timing: RTL and testbench



---
 rtl/ula_contention_timing_pkg.sv | 52 +++++
 rtl/ula_contention_timing_raster_counter.sv | 55 +++++
 rtl/ula_contention_timing.sv | 108 ++++++++++
 tb/tb_ula_contention_timing.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ula_contention_timing_pkg.sv
// Shared timing constants, types and the contention-slot decode for the ULA raster block.
// TIMING_128K_EN selects 128K line/frame lengths; otherwise 48K timing is used.
package ula_contention_timing_pkg;

    localparam int unsigned HC_W      = 9;
    localparam int unsigned VC_W      = 9;
    localparam int unsigned INT_CNT_W = 7;
    localparam int unsigned PHASE_W   = 3;

    localparam int unsigned CONT_SLOT_MAX = 5;
    localparam int unsigned DISP_H        = 256;
    localparam int unsigned DISP_V        = 192;

    localparam int unsigned HTOTAL_48K   = 448;
    localparam int unsigned VTOTAL_48K   = 312;
    localparam int unsigned INT_LEN_48K  = 64;
    localparam int unsigned HTOTAL_128K  = 456;
    localparam int unsigned VTOTAL_128K  = 311;
    localparam int unsigned INT_LEN_128K = 72;

    localparam int unsigned VINT_DEF       = 248;
    localparam int unsigned HINT_DEF       = 0;
    localparam int unsigned CONT_HOFS_128K = 2;

`ifdef TIMING_128K_EN
    localparam int unsigned HTOTAL_DEF  = HTOTAL_128K;
    localparam int unsigned VTOTAL_DEF  = VTOTAL_128K;
    localparam int unsigned INT_LEN_DEF = INT_LEN_128K;
`else
    localparam int unsigned HTOTAL_DEF  = HTOTAL_48K;
    localparam int unsigned VTOTAL_DEF  = VTOTAL_48K;
    localparam int unsigned INT_LEN_DEF = INT_LEN_48K;
`endif

    typedef struct packed {
        logic [HC_W-1:0] hc;
        logic [VC_W-1:0] vc;
    } raster_pos_t;

    typedef enum logic {
        INT_IDLE = 1'b0,
        INT_LOW  = 1'b1
    } int_state_e;

    // True while the ULA owns the bus: inside the bitmap area and in T-states 0..5 of each 8.
    function automatic logic in_cont_slot(input logic [HC_W-1:0] h, input logic [VC_W-1:0] v);
        logic [PHASE_W-1:0] phase;
        phase = h[PHASE_W:1];
        return (h < HC_W'(DISP_H)) && (v < VC_W'(DISP_V)) && (phase <= PHASE_W'(CONT_SLOT_MAX));
    endfunction

endpackage

// File: rtl/ula_contention_timing_raster_counter.sv
// Pixel/line raster counter advancing on the pixel enable, with a registered frame-start pulse.
module ula_contention_timing_raster_counter
    import ula_contention_timing_pkg::*;
#(
    parameter int unsigned HTOTAL = HTOTAL_DEF,
    parameter int unsigned VTOTAL = VTOTAL_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv_i,
    output raster_pos_t pos_o,
    output logic        tick_o,
    output logic        frame_start_o
);

    logic [HC_W-1:0] hc_q, hc_d;
    logic [VC_W-1:0] vc_q, vc_d;
    logic            tick_q;
    logic            fs_q, fs_d;

    // tick_q marks the clock right after a pixel advance, so 0,0 after reset is not a wrap.
    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        fs_d = tick_q && (hc_q == '0) && (vc_q == '0);
        if (adv_i) begin
            if (hc_q == HC_W'(HTOTAL - 1)) begin
                hc_d = '0;
                vc_d = (vc_q == VC_W'(VTOTAL - 1)) ? '0 : vc_q + VC_W'(1);
            end else begin
                hc_d = hc_q + HC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_q   <= '0;
            vc_q   <= '0;
            tick_q <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            hc_q   <= hc_d;
            vc_q   <= vc_d;
            tick_q <= adv_i;
            fs_q   <= fs_d;
        end
    end

    assign pos_o.hc      = hc_q;
    assign pos_o.vc      = vc_q;
    assign tick_o        = tick_q;
    assign frame_start_o = fs_q;

endmodule

// File: rtl/ula_contention_timing.sv
// ULA raster timing: hc/vc counters, frame interrupt and the CPU contention request.
// Define TIMING_128K_EN for 128K frame lengths and the 2-pixel shifted contention window.
module ula_contention_timing
    import ula_contention_timing_pkg::*;
#(
    parameter int unsigned HTOTAL  = HTOTAL_DEF,
    parameter int unsigned VTOTAL  = VTOTAL_DEF,
    parameter int unsigned VINT    = VINT_DEF,
    parameter int unsigned HINT    = HINT_DEF,
    parameter int unsigned INT_LEN = INT_LEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clk7en,
    input  logic            clk35en,
    input  logic            contention_en,
    input  logic            access_contended,
    output logic [HC_W-1:0] hc,
    output logic [VC_W-1:0] vc,
    output logic            int_n,
    output logic            frame_start,
    output logic            cpu_contention
);

    localparam logic [HC_W-1:0] INT_HC = HINT[HC_W-1:0];
    localparam logic [VC_W-1:0] INT_VC = VINT[VC_W-1:0];

    raster_pos_t          pos;
    logic                 tick;
    int_state_e           int_state_q, int_state_d;
    logic [INT_CNT_W-1:0] int_cnt_q, int_cnt_d;
    logic                 int_hit_c;
    logic                 cont_slot_c;
    logic                 cont_q, cont_d;

    ula_contention_timing_raster_counter #(
        .HTOTAL (HTOTAL),
        .VTOTAL (VTOTAL)
    ) u_raster (
        .clk           (clk),
        .rst_n         (rst_n),
        .adv_i         (clk7en),
        .pos_o         (pos),
        .tick_o        (tick),
        .frame_start_o (frame_start)
    );

    assign int_hit_c = tick && (pos.hc == INT_HC) && (pos.vc == INT_VC);

`ifdef TIMING_128K_EN
    logic [HC_W-1:0] hc_ofs_c;
    assign hc_ofs_c    = pos.hc - HC_W'(CONT_HOFS_128K);
    assign cont_slot_c = (pos.hc >= HC_W'(CONT_HOFS_128K)) && in_cont_slot(hc_ofs_c, pos.vc);
`else
    assign cont_slot_c = in_cont_slot(pos.hc, pos.vc);
`endif

    // Interrupt pulse: width counted in pixel ticks after int_n falls.
    always_comb begin
        int_state_d = int_state_q;
        int_cnt_d   = int_cnt_q;
        case (int_state_q)
            INT_IDLE: begin
                if (int_hit_c) begin
                    int_state_d = INT_LOW;
                    int_cnt_d   = '0;
                end
            end
            INT_LOW: begin
                if (clk7en) begin
                    if (int_cnt_q == INT_CNT_W'(INT_LEN - 1)) begin
                        int_state_d = INT_IDLE;
                        int_cnt_d   = '0;
                    end else begin
                        int_cnt_d = int_cnt_q + INT_CNT_W'(1);
                    end
                end
            end
            default: int_state_d = INT_IDLE;
        endcase
    end

    // Stall decision only moves on the CPU enable so it is stable for a whole T-state.
    always_comb begin
        cont_d = cont_q;
        if (clk35en) begin
            cont_d = contention_en && access_contended && cont_slot_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_state_q <= INT_IDLE;
            int_cnt_q   <= '0;
            cont_q      <= 1'b0;
        end else begin
            int_state_q <= int_state_d;
            int_cnt_q   <= int_cnt_d;
            cont_q      <= cont_d;
        end
    end

    assign hc             = pos.hc;
    assign vc             = pos.vc;
    assign int_n          = (int_state_q != INT_LOW);
    assign cpu_contention = cont_q;

endmodule

// File: tb/tb_ula_contention_timing.sv
// Scoreboard bench: four instances (default timing plus three short frames) against a tick-count model.
module tb_ula_contention_timing;
    import ula_contention_timing_pkg::*;

    localparam int NI = 4;
    localparam int unsigned HT [NI] = '{HTOTAL_DEF, 40, 40, 16};
    localparam int unsigned VT [NI] = '{VTOTAL_DEF, 12, 12, 200};
    localparam int unsigned VI [NI] = '{VINT_DEF, 9, 0, 195};
    localparam int unsigned HI [NI] = '{HINT_DEF, 5, 0, 3};
    localparam int unsigned IL [NI] = '{INT_LEN_DEF, 20, 20, 50};

    typedef struct packed {
        logic [8:0] hc;
        logic [8:0] vc;
        logic       int_n;
        logic       fs;
        logic       cont;
    } obs_t;
    typedef obs_t [NI-1:0] rec_t;

    logic clk = 1'b0;
    logic rst_n, clk7en, clk35en, contention_en, access_contended;
    logic [8:0] hc_w [NI];
    logic [8:0] vc_w [NI];
    logic int_n_w [NI];
    logic fs_w [NI];
    logic cont_w [NI];

    rec_t exp_q [$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    longint unsigned m_t [NI];
    longint unsigned m_end [NI];
    bit m_last [NI];
    bit m_int [NI];
    bit m_fs [NI];
    bit m_cont [NI];

    always #5 clk = ~clk;

    ula_contention_timing u_dut0 (
        .clk(clk), .rst_n(rst_n), .clk7en(clk7en), .clk35en(clk35en),
        .contention_en(contention_en), .access_contended(access_contended),
        .hc(hc_w[0]), .vc(vc_w[0]), .int_n(int_n_w[0]), .frame_start(fs_w[0]),
        .cpu_contention(cont_w[0]));

    ula_contention_timing #(.HTOTAL(HT[1]), .VTOTAL(VT[1]), .VINT(VI[1]), .HINT(HI[1]), .INT_LEN(IL[1])) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clk7en(clk7en), .clk35en(clk35en),
        .contention_en(contention_en), .access_contended(access_contended),
        .hc(hc_w[1]), .vc(vc_w[1]), .int_n(int_n_w[1]), .frame_start(fs_w[1]),
        .cpu_contention(cont_w[1]));

    ula_contention_timing #(.HTOTAL(HT[2]), .VTOTAL(VT[2]), .VINT(VI[2]), .HINT(HI[2]), .INT_LEN(IL[2])) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clk7en(clk7en), .clk35en(clk35en),
        .contention_en(contention_en), .access_contended(access_contended),
        .hc(hc_w[2]), .vc(vc_w[2]), .int_n(int_n_w[2]), .frame_start(fs_w[2]),
        .cpu_contention(cont_w[2]));

    ula_contention_timing #(.HTOTAL(HT[3]), .VTOTAL(VT[3]), .VINT(VI[3]), .HINT(HI[3]), .INT_LEN(IL[3])) u_dut3 (
        .clk(clk), .rst_n(rst_n), .clk7en(clk7en), .clk35en(clk35en),
        .contention_en(contention_en), .access_contended(access_contended),
        .hc(hc_w[3]), .vc(vc_w[3]), .int_n(int_n_w[3]), .frame_start(fs_w[3]),
        .cpu_contention(cont_w[3]));

    // Reference model: position is the tick count since reset taken modulo line/frame length.
    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_t[i] = 0; m_end[i] = 0; m_last[i] = 0;
            m_int[i] = 0; m_fs[i] = 0; m_cont[i] = 0;
        end
    endtask

    task automatic model_edge(input bit e7, input bit e35, input bit en, input bit acc);
        for (int i = 0; i < NI; i++) begin
            longint unsigned hp, vp;
            bit hit;
            hp = m_t[i] % HT[i];
            vp = (m_t[i] / HT[i]) % VT[i];
            hit = m_last[i] && (hp == HI[i]) && (vp == VI[i]);
            m_fs[i] = m_last[i] && ((m_t[i] % (HT[i] * VT[i])) == 0);
            if (e35) m_cont[i] = en && acc && (hp < 256) && (vp < 192) && (((hp % 16) / 2) <= 5);
            if (e7) m_t[i] = m_t[i] + 1;
            if (m_int[i] && (m_t[i] >= m_end[i])) m_int[i] = 0;
            if (hit && !m_int[i]) begin
                m_int[i] = 1;
                m_end[i] = m_t[i] + IL[i];
            end
            m_last[i] = e7;
        end
    endtask

    task automatic push_expect();
        rec_t r;
        for (int i = 0; i < NI; i++) begin
            r[i].hc    = 9'(m_t[i] % HT[i]);
            r[i].vc    = 9'((m_t[i] / HT[i]) % VT[i]);
            r[i].int_n = !m_int[i];
            r[i].fs    = m_fs[i];
            r[i].cont  = m_cont[i];
        end
        exp_q.push_back(r);
    endtask

    task automatic run_cycle(input int mode);
        @(negedge clk);
        cyc++;
        case (mode)
            4: begin clk7en = (cyc % 4 == 0); clk35en = (cyc % 8 == 0); end
            1: begin clk7en = 1'b1; clk35en = (cyc % 2 == 0); end
            default: begin clk7en = ($urandom_range(2) == 0); clk35en = ($urandom_range(3) == 0); end
        endcase
        access_contended = ($urandom_range(3) != 0);
        contention_en    = ($urandom_range(9) != 0);
        @(posedge clk);
        if (rst_n) model_edge(clk7en, clk35en, contention_en, access_contended);
        else model_reset();
        #1 push_expect();
    endtask

    // Monitor: one expected record per presented output sample.
    initial begin
        rec_t r;
        forever begin
            wait (exp_q.size() > 0);
            r = exp_q.pop_front();
            vectors++;
            for (int i = 0; i < NI; i++) begin
                if (hc_w[i] !== r[i].hc) begin
                    miscompares++;
                    $display("FAIL hc inst%0d vec%0d got %0d want %0d", i, vectors, hc_w[i], r[i].hc);
                end
                if (vc_w[i] !== r[i].vc) begin
                    miscompares++;
                    $display("FAIL vc inst%0d vec%0d got %0d want %0d", i, vectors, vc_w[i], r[i].vc);
                end
                if (int_n_w[i] !== r[i].int_n) begin
                    miscompares++;
                    $display("FAIL int_n inst%0d vec%0d got %0b want %0b", i, vectors, int_n_w[i], r[i].int_n);
                end
                if (fs_w[i] !== r[i].fs) begin
                    miscompares++;
                    $display("FAIL frame_start inst%0d vec%0d got %0b want %0b", i, vectors, fs_w[i], r[i].fs);
                end
                if (cont_w[i] !== r[i].cont) begin
                    miscompares++;
                    $display("FAIL cpu_contention inst%0d vec%0d got %0b want %0b", i, vectors, cont_w[i], r[i].cont);
                end
            end
        end
    end

    initial begin
        bit found;
        clk7en = 1'b0; clk35en = 1'b0; contention_en = 1'b0; access_contended = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        #1 push_expect();
        repeat (3) run_cycle(4);
        rst_n = 1'b1;

        // Run until instance 1 is eight ticks into its interrupt, then reset asynchronously.
        found = 0;
        for (int k = 0; k < 3000 && !found; k++) begin
            run_cycle(4);
            if (m_int[1] && (m_t[1] + IL[1] >= m_end[1] + 8)) found = 1;
        end
        if (!found) begin
            miscompares++;
            $display("FAIL reset_window got no int_n low window want int_n low within 3000 clk");
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1 push_expect();
        run_cycle(4);
        rst_n = 1'b1;

        repeat (2400) run_cycle(4);
        repeat (12000) run_cycle(1);
        repeat (3000) run_cycle(0);

        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
